// File: rtl/tlb_op_sequencer_pkg.sv
// Shared TLB maintenance types.
//   TLBEntry    : one TLB entry as assembled from EntryHi/Lo0/Lo1/PageMask
//   TLBOp       : CP0 TLB instruction encoding (op_code)
//   seq_state_e : sequencer FSM states
package tlb_op_sequencer_pkg;

  localparam int VPN2_W = 19;
  localparam int ASID_W = 8;

  typedef struct packed {
    logic [VPN2_W-1:0] vpn2;
    logic [ASID_W-1:0] asid;
    logic [11:0]       mask;
    logic              g;
    logic [19:0]       pfn0;
    logic [2:0]        c0;
    logic              d0;
    logic              v0;
    logic [19:0]       pfn1;
    logic [2:0]        c1;
    logic              d1;
    logic              v1;
  } TLBEntry;

  typedef enum logic [1:0] {
    TLBP  = 2'b00,
    TLBR  = 2'b01,
    TLBWI = 2'b10,
    TLBWR = 2'b11
  } TLBOp;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    READ  = 2'b10,
    WRITE = 2'b11
  } seq_state_e;

endpackage

// File: rtl/tlb_op_sequencer_if.sv
// Bundle between the TLB op sequencer and its surroundings (CP0 + TLB).
//   master : the sequencer (drives op_ready, probe/read/write requests,
//            writeback results and Random)
//   slave  : CP0 and the TLB (drive ops, CP0 register values, readies)
interface tlb_op_sequencer_if #(
  parameter int NUM_ENTRIES = 64,
  parameter int IW          = $clog2(NUM_ENTRIES)
) ();
  import tlb_op_sequencer_pkg::*;

  // CP0 instruction side
  logic                op_valid;
  TLBOp                op_code;
  logic                op_ready;
  logic [VPN2_W-1:0]   cp0_vpn2;
  logic [ASID_W-1:0]   cp0_asid;
  logic [IW-1:0]       cp0_index;
  logic [IW-1:0]       cp0_wired;
  logic                wired_we;
  TLBEntry             cp0_entry;

  // TLB probe port
  logic                p_valid;
  logic [VPN2_W-1:0]   p_ivpn2;
  logic [ASID_W-1:0]   p_iasid;
  logic                p_ready;
  logic [IW-1:0]       p_index;
  logic                p_miss;

  // TLB read port
  logic [IW-1:0]       r_index;
  logic                r_ready;
  TLBEntry             r_resp;

  // TLB write port
  logic                w_valid;
  logic [IW-1:0]       w_index;
  TLBEntry             w_data;
  logic                w_ready;

  // CP0 writeback
  logic                done_valid;
  logic                res_index_we;
  logic                res_probe_fail;
  logic [IW-1:0]       res_index;
  logic                res_entry_we;
  TLBEntry             res_entry;
  logic                res_error;
  logic [IW-1:0]       random;

  modport master (
    input  op_valid, op_code, cp0_vpn2, cp0_asid, cp0_index, cp0_wired,
           wired_we, cp0_entry, p_ready, p_index, p_miss, r_ready, r_resp,
           w_ready,
    output op_ready, p_valid, p_ivpn2, p_iasid, r_index, w_valid, w_index,
           w_data, done_valid, res_index_we, res_probe_fail, res_index,
           res_entry_we, res_entry, res_error, random
  );

  modport slave (
    output op_valid, op_code, cp0_vpn2, cp0_asid, cp0_index, cp0_wired,
           wired_we, cp0_entry, p_ready, p_index, p_miss, r_ready, r_resp,
           w_ready,
    input  op_ready, p_valid, p_ivpn2, p_iasid, r_index, w_valid, w_index,
           w_data, done_valid, res_index_we, res_probe_fail, res_index,
           res_entry_we, res_entry, res_error, random
  );

endinterface

// File: rtl/tlb_op_sequencer_random_counter.sv
// CP0 Random register. Counts down every cycle from NUM_ENTRIES-1 and wraps
// back to the top once it is at or below Wired, so entries below Wired are
// never chosen by TLBWR.
//   clock, reset : clock, async active-high reset (Random -> NUM_ENTRIES-1)
//   i_wired      : current Wired value
//   i_wired_we   : Wired written this cycle; reloads Random (highest priority)
//   i_hold       : freeze Random (TLBWR in flight)
//   o_random     : Random register
module tlb_random_counter #(
  parameter int NUM_ENTRIES = 64,
  parameter int IW          = $clog2(NUM_ENTRIES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [IW-1:0] i_wired,
  input  logic          i_wired_we,
  input  logic          i_hold,
  output logic [IW-1:0] o_random
);

  localparam logic [IW-1:0] MAX = IW'(NUM_ENTRIES - 1);

  logic [IW-1:0] r_random;

  // Wired = NUM_ENTRIES-1 falls out of the wrap test: Random is always <= it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  r_random <= MAX;
    else if (i_wired_we)        r_random <= MAX;
    else if (i_hold)            r_random <= r_random;
    else if (r_random <= i_wired) r_random <= MAX;
    else                        r_random <= r_random - 1'b1;
  end

  assign o_random = r_random;

endmodule

// File: rtl/tlb_op_sequencer.sv
// Initiator side of the TLB maintenance interface. Runs one CP0 TLB
// instruction (TLBP/TLBR/TLBWI/TLBWR) at a time, holds the matching TLB
// request until its ready, then pulses done_valid with writeback results.
// Read/write waits are bounded by a watchdog (TIMEOUT cycles); probe waits
// are not, the TLB always terminates a probe.
//   clock, reset : clock, async active-high reset
//   bus          : master side of tlb_op_sequencer_if (ops, TLB ports,
//                  writeback, Random)
module tlb_op_sequencer
  import tlb_op_sequencer_pkg::*;
#(
  parameter int NUM_ENTRIES = 64,
  parameter int TIMEOUT     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  tlb_op_sequencer_if.master   bus
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  seq_state_e        r_state, w_next;
  TLBOp              r_op;
  logic [VPN2_W-1:0] r_vpn2;
  logic [ASID_W-1:0] r_asid;
  TLBEntry           r_entry;
  logic [IW-1:0]     r_idx;
  logic [TW-1:0]     r_wdog;

  logic              r_done;
  logic              r_index_we;
  logic              r_probe_fail;
  logic [IW-1:0]     r_res_index;
  logic              r_entry_we;
  TLBEntry           r_res_entry;
  logic              r_error;

  logic              w_accept;
  logic              w_ok;       // matching ready seen this cycle
  logic              w_timeout;  // watchdog expired this cycle
  logic              w_hold;
  logic [IW-1:0]     w_random;

  assign w_accept = bus.op_valid && (r_state == IDLE);
  // Random must not move while a TLBWR is writing the slot it picked.
  assign w_hold   = (r_state == WRITE) && (r_op == TLBWR);

  tlb_random_counter #(.NUM_ENTRIES(NUM_ENTRIES)) u_random (
    .clock      (clock),
    .reset      (reset),
    .i_wired    (bus.cp0_wired),
    .i_wired_we (bus.wired_we),
    .i_hold     (w_hold),
    .o_random   (w_random)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_ok      = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (bus.op_code)
            TLBP:    w_next = PROBE;
            TLBR:    w_next = READ;
            default: w_next = WRITE;
          endcase
        end
      end
      PROBE: begin
        if (bus.p_ready) begin
          w_ok   = 1'b1;
          w_next = IDLE;
        end
      end
      READ: begin
        if (bus.r_ready) begin
          w_ok   = 1'b1;
          w_next = IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      WRITE: begin
        if (bus.w_ready) begin
          w_ok   = 1'b1;
          w_next = IDLE;
        end else if (r_wdog == WDOG_LAST) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operands captured at accept so CP0 may change underneath the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op    <= TLBP;
      r_vpn2  <= '0;
      r_asid  <= '0;
      r_entry <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_op    <= bus.op_code;
      r_vpn2  <= bus.cp0_vpn2;
      r_asid  <= bus.cp0_asid;
      r_entry <= bus.cp0_entry;
      r_idx   <= (bus.op_code == TLBWR) ? w_random : bus.cp0_index;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                       r_wdog <= '0;
    else if (w_accept)                               r_wdog <= '0;
    else if ((r_state == READ) || (r_state == WRITE)) r_wdog <= r_wdog + 1'b1;
  end

  // Writeback: strobes live for the single done cycle, data fields hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_done       <= 1'b0;
      r_index_we   <= 1'b0;
      r_probe_fail <= 1'b0;
      r_res_index  <= '0;
      r_entry_we   <= 1'b0;
      r_res_entry  <= '0;
      r_error      <= 1'b0;
    end else begin
      r_done     <= w_ok || w_timeout;
      r_index_we <= w_ok && (r_state == PROBE);
      r_entry_we <= w_ok && (r_state == READ);
      r_error    <= w_timeout;
      if (w_ok && (r_state == PROBE)) begin
        r_probe_fail <= bus.p_miss;
        r_res_index  <= bus.p_miss ? '0 : bus.p_index;
      end
      if (w_ok && (r_state == READ)) r_res_entry <= bus.r_resp;
    end
  end

  // Requests decode straight from the state register so an async reset
  // drops them without waiting for a clock edge.
  always_comb begin
    bus.op_ready = (r_state == IDLE);
    bus.p_valid  = (r_state == PROBE);
    bus.w_valid  = (r_state == WRITE);
  end

  assign bus.p_ivpn2        = r_vpn2;
  assign bus.p_iasid        = r_asid;
  assign bus.r_index        = r_idx;
  assign bus.w_index        = r_idx;
  assign bus.w_data         = r_entry;
  assign bus.done_valid     = r_done;
  assign bus.res_index_we   = r_index_we;
  assign bus.res_probe_fail = r_probe_fail;
  assign bus.res_index      = r_res_index;
  assign bus.res_entry_we   = r_entry_we;
  assign bus.res_entry      = r_res_entry;
  assign bus.res_error      = r_error;
  assign bus.random         = w_random;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Directed bench for tlb_op_sequencer: probe hit/miss, read, TLBWI/TLBWR,
// Random behaviour, watchdog abort and async reset abort.
module tb_tlb_op_sequencer;
  import tlb_op_sequencer_pkg::*;

  localparam int NE = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  tlb_op_sequencer_if #(.NUM_ENTRIES(NE)) bus ();

  tlb_op_sequencer #(.NUM_ENTRIES(NE), .TIMEOUT(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  TLBEntry e_rd, e_wr;

  initial begin
    int  pv, early, n, ok, found, dn;
    logic [5:0] rexp [5];

    e_rd = TLBEntry'({26'h0, 32'hDEADBEEF, 32'h12345678});
    e_wr = TLBEntry'({26'h155, 32'hCAFEF00D, 32'h0BADC0DE});

    bus.op_valid  = 1'b0;
    bus.op_code   = TLBP;
    bus.cp0_vpn2  = '0;
    bus.cp0_asid  = '0;
    bus.cp0_index = '0;
    bus.cp0_wired = '0;
    bus.wired_we  = 1'b0;
    bus.cp0_entry = '0;
    bus.p_ready   = 1'b0;
    bus.p_index   = '0;
    bus.p_miss    = 1'b0;
    bus.r_ready   = 1'b0;
    bus.r_resp    = '0;
    bus.w_ready   = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_op_ready", 128'(bus.op_ready),   128'(1));
    chk("rst_p_valid",  128'(bus.p_valid),    128'(0));
    chk("rst_w_valid",  128'(bus.w_valid),    128'(0));
    chk("rst_done",     128'(bus.done_valid), 128'(0));
    chk("rst_random",   128'(bus.random),     128'(63));
    reset = 1'b0;

    // TLBP hit, ready in the first request cycle
    bus.op_valid = 1'b1; bus.op_code = TLBP;
    bus.cp0_vpn2 = 19'h12345; bus.cp0_asid = 8'h07;
    tick();
    bus.op_valid = 1'b0; bus.cp0_vpn2 = '0; bus.cp0_asid = '0;
    chk("p_valid",  128'(bus.p_valid),  128'(1));
    chk("p_ivpn2",  128'(bus.p_ivpn2),  128'(19'h12345));
    chk("p_iasid",  128'(bus.p_iasid),  128'(8'h07));
    chk("busy",     128'(bus.op_ready), 128'(0));
    bus.p_ready = 1'b1; bus.p_index = 6'd5;
    tick();
    bus.p_ready = 1'b0;
    chk("hit_done",  128'(bus.done_valid),     128'(1));
    chk("hit_we",    128'(bus.res_index_we),   128'(1));
    chk("hit_pfail", 128'(bus.res_probe_fail), 128'(0));
    chk("hit_index", 128'(bus.res_index),      128'(5));
    chk("hit_ewe",   128'(bus.res_entry_we),   128'(0));
    chk("hit_rdy",   128'(bus.op_ready),       128'(1));
    chk("hit_pdrop", 128'(bus.p_valid),        128'(0));
    tick();
    chk("hit_pulse", 128'(bus.done_valid),   128'(0));
    chk("hit_we_off",128'(bus.res_index_we), 128'(0));

    // TLBP miss after 16 stall cycles
    bus.op_valid = 1'b1; bus.op_code = TLBP;
    bus.cp0_vpn2 = 19'h7FFFF; bus.cp0_asid = 8'hA5;
    tick();
    bus.op_valid = 1'b0;
    pv = 0; early = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin bus.p_ready = 1'b1; bus.p_miss = 1'b1; bus.p_index = 6'd12; end
      if (bus.p_valid && bus.p_ivpn2 == 19'h7FFFF) pv++;
      if (bus.done_valid) early++;
      tick();
    end
    bus.p_ready = 1'b0; bus.p_miss = 1'b0;
    chk("miss_pcycles", 128'(pv),                 128'(17));
    chk("miss_early",   128'(early),              128'(0));
    chk("miss_done",    128'(bus.done_valid),     128'(1));
    chk("miss_we",      128'(bus.res_index_we),   128'(1));
    chk("miss_pfail",   128'(bus.res_probe_fail), 128'(1));
    chk("miss_index",   128'(bus.res_index),      128'(0));

    // TLBR index 9, ready after 3 waits; back-to-back TLBWI on done cycle
    bus.op_valid = 1'b1; bus.op_code = TLBR; bus.cp0_index = 6'd9;
    tick();
    bus.op_valid = 1'b0; bus.cp0_index = 6'd2;
    ok = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin bus.r_ready = 1'b1; bus.r_resp = e_rd; end
      if (bus.r_index != 6'd9 || bus.op_ready) ok = 0;
      tick();
    end
    bus.r_ready = 1'b0; bus.r_resp = '0;
    chk("rd_stable",  128'(ok),                 128'(1));
    chk("rd_done",    128'(bus.done_valid),     128'(1));
    chk("rd_ewe",     128'(bus.res_entry_we),   128'(1));
    chk("rd_entry",   128'(bus.res_entry),      128'(e_rd));
    chk("rd_iwe",     128'(bus.res_index_we),   128'(0));
    bus.op_valid = 1'b1; bus.op_code = TLBWI;
    bus.cp0_index = 6'd3; bus.cp0_entry = e_wr;
    tick();
    bus.op_valid = 1'b1; bus.op_code = TLBP;  // busy: must be dropped
    bus.cp0_index = 6'd0; bus.cp0_entry = '0;
    chk("wi_wvalid", 128'(bus.w_valid),    128'(1));
    chk("wi_windex", 128'(bus.w_index),    128'(3));
    chk("wi_wdata",  128'(bus.w_data),     128'(e_wr));
    chk("wi_pulse",  128'(bus.done_valid), 128'(0));
    tick();
    bus.op_valid = 1'b0; bus.w_ready = 1'b1;
    tick();
    bus.w_ready = 1'b0;
    chk("wi_done",  128'(bus.done_valid),   128'(1));
    chk("wi_flags", 128'({bus.res_index_we, bus.res_entry_we, bus.res_error}), 128'(0));
    tick();
    chk("wi_noq_p",  128'(bus.p_valid),  128'(0));
    chk("wi_noq_rdy",128'(bus.op_ready), 128'(1));

    // TLBWR with Random = 40 at accept, w_ready after 2 waits
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.random == 6'd40) begin found = 1; break; end
      tick();
    end
    chk("wr_find40", 128'(found), 128'(1));
    bus.op_valid = 1'b1; bus.op_code = TLBWR;
    bus.cp0_index = 6'd7; bus.cp0_entry = e_rd;
    tick();
    bus.op_valid = 1'b0;
    ok = 1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.w_ready = 1'b1;
      if (!bus.w_valid || bus.w_index != 6'd40 || bus.random != 6'd39) ok = 0;
      tick();
    end
    bus.w_ready = 1'b0;
    chk("wr_stable", 128'(ok),             128'(1));
    chk("wr_done",   128'(bus.done_valid), 128'(1));
    chk("wr_rnd_hd", 128'(bus.random),     128'(39));
    tick();
    chk("wr_rnd_go", 128'(bus.random),     128'(38));

    // Random with Wired = 60
    bus.wired_we = 1'b1; bus.cp0_wired = 6'd60;
    tick();
    bus.wired_we = 1'b0;
    chk("rnd_load", 128'(bus.random), 128'(63));
    rexp[0] = 6'd62; rexp[1] = 6'd61; rexp[2] = 6'd60; rexp[3] = 6'd63; rexp[4] = 6'd62;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rnd_seq%0d", i), 128'(bus.random), 128'(rexp[i]));
    end
    tick();
    chk("rnd_61", 128'(bus.random), 128'(61));
    bus.wired_we = 1'b1;
    tick();
    bus.wired_we = 1'b0;
    chk("rnd_wwe", 128'(bus.random), 128'(63));
    bus.cp0_wired = 6'd63;
    tick();
    chk("rnd_w63a", 128'(bus.random), 128'(63));
    tick();
    chk("rnd_w63b", 128'(bus.random), 128'(63));
    bus.cp0_wired = 6'd0;

    // TLBR watchdog, with stray probe/write readies that must be ignored
    bus.op_valid = 1'b1; bus.op_code = TLBR; bus.cp0_index = 6'd4;
    tick();
    bus.op_valid = 1'b0; bus.p_ready = 1'b1; bus.w_ready = 1'b1;
    n = 0;
    while (!bus.done_valid && n < 50) begin
      if (!bus.op_ready) n++;
      tick();
    end
    bus.p_ready = 1'b0; bus.w_ready = 1'b0;
    chk("to_cycles", 128'(n),                128'(32));
    chk("to_done",   128'(bus.done_valid),   128'(1));
    chk("to_error",  128'(bus.res_error),    128'(1));
    chk("to_we",     128'({bus.res_index_we, bus.res_entry_we}), 128'(0));
    tick();
    chk("to_err_off",128'(bus.res_error),    128'(0));

    // async reset in the middle of a write
    bus.op_valid = 1'b1; bus.op_code = TLBWI; bus.cp0_index = 6'd3;
    tick();
    bus.op_valid = 1'b0;
    chk("ar_wvalid", 128'(bus.w_valid), 128'(1));
    tick();
    #2 reset = 1'b1;
    #1;
    chk("ar_wdrop",  128'(bus.w_valid),  128'(0));
    chk("ar_rdy",    128'(bus.op_ready), 128'(1));
    chk("ar_random", 128'(bus.random),   128'(63));
    tick();
    reset = 1'b0; bus.w_ready = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.done_valid) dn++;
      tick();
    end
    bus.w_ready = 1'b0;
    chk("ar_nodone", 128'(dn), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_op_sequencer.md
Name: tlb_op_sequencer

Overview:
- Initiator side of the TLB maintenance interface. Executes the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR one at a time.
- Drives the TLB probe, read and write ports with level-held requests and waits for the matching ready.
- Returns Index/P-bit and entry results to CP0 writeback.
- Owns the CP0 Random register, bounded below by Wired.

Parameters:
NUM_ENTRIES, 64, TLB entry count; IW = $clog2(NUM_ENTRIES)
TIMEOUT, 32, max cycles waiting for r_ready/w_ready before abort

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  TLB instruction request
op_code  in  2  00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
op_ready  out  1  sequencer idle; op accepted when op_valid&&op_ready
cp0_vpn2  in  19  EntryHi.VPN2
cp0_asid  in  8  EntryHi.ASID
cp0_index  in  IW  Index register
cp0_wired  in  IW  Wired register value
wired_we  in  1  Wired being written this cycle
cp0_entry  in  TLBEntry  entry assembled from EntryHi/Lo0/Lo1/PageMask
p_valid  out  1  probe request
p_ivpn2  out  19  probe VPN2
p_iasid  out  8  probe ASID
p_ready  in  1  probe done (hit or miss)
p_index  in  IW  probe hit index
p_miss  in  1  probe miss, valid with p_ready
r_index  out  IW  read index
r_ready  in  1  read data valid
r_resp  in  TLBEntry  read data
w_valid  out  1  write request
w_index  out  IW  write index
w_data  out  TLBEntry  write data
w_ready  in  1  write accepted
done_valid  out  1  one-cycle completion pulse
res_index_we  out  1  with done: write Index (TLBP)
res_probe_fail  out  1  P bit value
res_index  out  IW  Index value
res_entry_we  out  1  with done: write EntryHi/Lo/PageMask (TLBR)
res_entry  out  TLBEntry  entry read
res_error  out  1  with done: timeout abort
random  out  IW  Random register

Behaviour:
- Reset (async): FSM=IDLE, random=NUM_ENTRIES-1, all other outputs 0.
- FSM states: IDLE, PROBE, READ, WRITE.
  - IDLE: op_ready=1. On accept, latch op_code, vpn2, asid, cp0_entry and the target index, then go to PROBE/READ/WRITE. Target index is cp0_index for TLBR/TLBWI and random (sampled at the accept edge) for TLBWR.
  - PROBE: p_valid=1, ivpn2/iasid held from the latches. Wait for p_ready with no timeout, because the TLB guarantees miss termination.
  - READ: r_index=latched index; wait r_ready.
  - WRITE: w_valid=1, w_index/w_data held; wait w_ready.
- Request outputs are stable from entry to the ready cycle. They drop the cycle after ready.
- On the ready cycle, go to IDLE and register done_valid=1 for exactly one cycle, plus the result fields:
  - TLBP hit: res_index_we=1, res_probe_fail=0, res_index=p_index.
  - TLBP miss: res_index_we=1, res_probe_fail=1, res_index=0.
  - TLBR: res_entry_we=1, res_entry=r_resp.
  - TLBWI/TLBWR: no we flags.
- Latency with same-cycle ready: accept T0, request T1, done_valid and op_ready both high at T2. Back-to-back accept at T2 is legal.
- Watchdog: a counter starts at 0 on READ/WRITE entry and increments each waiting cycle. When it reaches TIMEOUT-1 without ready:
  - drop the request, go to IDLE;
  - pulse done_valid with res_error=1 and both we flags 0.
- Random, updated every cycle:
  - wired_we: random <= NUM_ENTRIES-1; this has priority over all other updates.
  - else if random <= cp0_wired: wrap to NUM_ENTRIES-1.
  - else: decrement.
  - Held (no update) while FSM is WRITE for a TLBWR.
  - If cp0_wired = NUM_ENTRIES-1, random stays NUM_ENTRIES-1.
- op_valid while busy is ignored; it is not queued.
- Ready inputs outside the matching state are ignored.
- Reset mid-operation aborts immediately: requests deassert asynchronously and no done pulse is produced.

Decomposition:
- Shared TLB types package holds:
  - TLBEntry;
  - the op_code enum TLBOp {TLBP, TLBR, TLBWI, TLBWR};
  - the FSM state enum.
- Random/Wired counter is a natural sub-module: tlb_random_counter (NUM_ENTRIES; clock, reset, wired, wired_we, hold -> random).

Test Plan:
- TLBP, vpn2=0x12345 asid=0x07, p_ready+p_index=5 at T1 -> done_valid at T2, res_index_we=1, res_probe_fail=0, res_index=5.
- TLBP with p_miss=1 after 16 stall cycles -> p_valid held 17 cycles, then done with res_probe_fail=1, res_index=0.
- TLBR index=9, r_ready after 3 cycles -> r_index=9 stable throughout, res_entry_we=1, res_entry==r_resp.
- TLBWR with random=40 at accept, w_ready after 2 cycles -> w_index=40 throughout and random frozen. TLBWI index=3 -> w_index=3.
- Random, wired=60: decrements 63..60, then wraps to 63. wired_we pulse mid-count -> 63 next cycle.
- TLBR with r_ready never asserted, TIMEOUT=32 -> request drops after 32 cycles, done_valid with res_error=1. Reset asserted mid-WRITE -> w_valid=0 immediately, no done pulse.
